vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 176 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA timing recovery: measures hsync/vsync periods, locks onto stable timing and
// emits active-area pixel coordinates, data-enable and colour two clocks after the pins.
module vga_sync_decoder #(
  parameter int H_ACT_START = 145,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 36,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk25MHz,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        sync_err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] SAT = 10'h3FF;

  logic        r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs;
  logic [11:0] r_s1_rgb;
  logic [9:0]  r_hpos, r_vpos, r_first_h, r_ref_h, r_ref_v, r_h_total, r_v_total;
  logic [MW-1:0] r_match;
  logic        r_frame_bad;
  state_t      r_state, w_state_nxt;

  logic [9:0]  r_px_x, r_px_y;
  logic [11:0] r_rgb;
  logic        r_de, r_fs, r_sync_err;

  logic        w_h_edge, w_v_edge, w_sat, w_line_bad, w_vlen_bad, w_frame_bad;
  logic        w_sync_err, w_load_ref, w_match_clr, w_match_inc, w_de;
  logic [9:0]  w_hpos, w_vpos, w_line_len, w_frame_len, w_px_x, w_px_y;

  // Position of the sample currently in S1, plus line/frame measurements.
  always_comb begin
    w_h_edge    = r_s1_hs & ~r_s2_hs;
    w_v_edge    = r_s1_vs & ~r_s2_vs;
    w_hpos      = w_h_edge ? '0 : ((r_hpos == SAT) ? SAT : r_hpos + 10'd1);
    w_vpos      = r_vpos;
    if (w_v_edge)
      w_vpos = '0;
    else if (w_h_edge)
      w_vpos = (r_vpos == SAT) ? SAT : r_vpos + 10'd1;
    w_line_len  = r_hpos + 10'd1;
    w_frame_len = r_vpos + 10'd1;
    w_sat       = (w_hpos == SAT) || (w_vpos == SAT);
    w_line_bad  = w_h_edge && (w_line_len != r_ref_h);
    w_vlen_bad  = (w_frame_len != r_ref_v);
    w_frame_bad = r_frame_bad || w_line_bad || w_vlen_bad;
    w_de        = (r_state == LOCKED)
               && (int'(w_hpos) >= H_ACT_START) && (int'(w_hpos) < H_ACT_START + H_ACT)
               && (int'(w_vpos) >= V_ACT_START) && (int'(w_vpos) < V_ACT_START + V_ACT);
    w_px_x      = w_de ? w_hpos - 10'(H_ACT_START) : '0;
    w_px_y      = w_de ? w_vpos - 10'(V_ACT_START) : '0;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_sync_err  = 1'b0;
    w_load_ref  = 1'b0;
    w_match_clr = 1'b0;
    w_match_inc = 1'b0;
    if (w_sat) begin
      w_state_nxt = SEARCH;
      w_sync_err  = (r_state == LOCKED);
    end else begin
      case (r_state)
        SEARCH:  if (w_v_edge) w_state_nxt = MEASURE;
        MEASURE: if (w_v_edge) begin
          w_load_ref  = 1'b1;
          w_match_clr = 1'b1;
          w_state_nxt = CHECK;
        end
        CHECK:   if (w_v_edge) begin
          if (w_frame_bad) begin
            w_load_ref  = 1'b1;
            w_match_clr = 1'b1;
          end else if (int'(r_match) + 1 >= LOCK_FRAMES) begin
            w_match_clr = 1'b1;
            w_state_nxt = LOCKED;
          end else begin
            w_match_inc = 1'b1;
          end
        end
        LOCKED:  if (w_line_bad || (w_v_edge && w_vlen_bad)) begin
          w_sync_err  = 1'b1;
          w_state_nxt = MEASURE;
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) r_state <= SEARCH;
    else       r_state <= w_state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so S2 samples the old S1 value.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
      r_s1_rgb    <= '0;
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_h_total   <= '0;
      r_v_total   <= '0;
      r_first_h   <= '0;
      r_frame_bad <= 1'b0;
      r_ref_h     <= '0;
      r_ref_v     <= '0;
      r_match     <= '0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_fs        <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_s1_hs  <= hsync;
      r_s1_vs  <= vsync;
      r_s1_rgb <= {red, green, blue};
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_hpos   <= w_hpos;
      r_vpos   <= w_vpos;
      if (w_h_edge) r_h_total <= w_line_len;
      if (w_v_edge) r_v_total <= w_frame_len;
      // Length of line 0 of the current frame becomes the line reference.
      if (w_h_edge && !w_v_edge && r_vpos == '0) r_first_h <= w_line_len;
      if (w_v_edge)        r_frame_bad <= 1'b0;
      else if (w_line_bad) r_frame_bad <= 1'b1;
      if (w_load_ref) begin
        r_ref_h <= r_first_h;
        r_ref_v <= w_frame_len;
      end
      if (w_match_clr)      r_match <= '0;
      else if (w_match_inc) r_match <= r_match + 1'b1;
      r_px_x     <= w_px_x;
      r_px_y     <= w_px_y;
      r_de       <= w_de;
      r_rgb      <= w_de ? r_s1_rgb : '0;
      r_fs       <= w_v_edge;
      r_sync_err <= w_sync_err;
    end
  end

  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign de          = r_de;
  assign rgb_out     = r_rgb;
  assign frame_start = r_fs;
  assign locked      = (r_state == LOCKED);
  assign h_total     = r_h_total;
  assign v_total     = r_v_total;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scaled-timing bench: 64-clock lines, 30/31-line frames, scoreboarded per-sample outputs
// plus directed checks of lock, measurement and reset behaviour.
module tb_vga_sync_decoder;

  localparam int LINE = 64, HS_W = 8, VS_L = 2;
  localparam int HAS = 20, HA = 32, VAS = 5, VA = 20, LF = 2;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync;
  logic [3:0]  red, green, blue;
  logic [9:0]  px_x, px_y, h_total, v_total;
  logic        de, frame_start, locked, sync_err;
  logic [11:0] rgb_out;

  vga_sync_decoder #(
    .H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk25MHz(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .px_x(px_x), .px_y(px_y), .de(de), .rgb_out(rgb_out),
    .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [34:0] exp;   // {de, px_x, px_y, rgb_out, frame_start, sync_err}
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  n_vec = 0, n_err = 0, de_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    sb_t e;
    logic [34:0] obs;
    if (de === 1'b1) de_cnt = de_cnt + 1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      obs = {de, px_x, px_y, rgb_out, frame_start, sync_err};
      n_vec++;
      assert (e.due == cyc && obs === e.exp) else begin
        n_err++;
        $error("FAIL sb cycle %0d due %0d: got %h want %h", cyc, e.due, obs, e.exp);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_de"}, 32'(de), 0);
    check({tag, "_px_x"}, 32'(px_x), 0);
    check({tag, "_px_y"}, 32'(px_y), 0);
    check({tag, "_rgb"}, 32'(rgb_out), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_h_total"}, 32'(h_total), 0);
    check({tag, "_v_total"}, 32'(v_total), 0);
    check({tag, "_sync_err"}, 32'(sync_err), 0);
  endtask

  // One pin sample; its outputs are due two clocks later.
  task automatic drive(input logic hs, input logic vs, input logic [11:0] c, input logic [34:0] exp);
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    {red, green, blue} = c;
    q.push_back('{due: cyc + 2, exp: exp});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hsync = 1'b0;
      vsync = 1'b0;
      {red, green, blue} = 12'h0;
    end
  endtask

  // nl lines of nominal timing; short_l shortens that line by one clock (expects a line error
  // at the next hsync edge); err_start expects a frame error at this frame's vsync edge.
  task automatic frame(input int nl, input int short_l, input logic lock_e, input logic err_start);
    logic lk, act, e;
    logic [11:0] c;
    int len;
    lk = lock_e;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? LINE - 1 : LINE;
      for (int p = 0; p < len; p++) begin
        e = 1'b0;
        if (p == 0 && l == 0 && err_start) e = 1'b1;
        if (p == 0 && short_l >= 0 && l == short_l + 1) begin
          e  = 1'b1;
          lk = 1'b0;
        end
        c   = 12'(p * 37 + l * 5);
        act = lk && p >= HAS && p < HAS + HA && l >= VAS && l < VAS + VA;
        drive(p < HS_W, l < VS_L, c,
              {act, act ? 10'(p - HAS) : 10'd0, act ? 10'(l - VAS) : 10'd0,
               act ? c : 12'd0, (p == 0 && l == 0), e});
      end
    end
  endtask

  task automatic hold_low(input int n, input int err_k);
    for (int k = 0; k < n; k++)
      drive(1'b0, 1'b0, 12'(k * 3), {33'd0, 1'b0, (k == err_k)});
  endtask

  initial begin
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    {red, green, blue} = 12'h0;
    idle(3);
    outputs_zero("reset");
    reset = 1'b0;

    // Lock from reset: 4th vsync edge.
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b1, 1'b0);
    check("locked_nominal", 32'(locked), 1);
    check("h_total_nominal", 32'(h_total), LINE);
    check("v_total_nominal", 32'(v_total), 30);
    de_cnt = 0;
    frame(30, -1, 1'b1, 1'b0);
    check("de_per_frame", de_cnt, HA * VA);

    // Switch to 31-line frames, relock, then one 30-line frame.
    frame(31, -1, 1'b1, 1'b0);
    frame(31, -1, 1'b0, 1'b1);
    frame(31, -1, 1'b0, 1'b0);
    frame(31, -1, 1'b0, 1'b0);
    check("unlocked_before_relock", 32'(locked), 0);
    frame(31, -1, 1'b1, 1'b0);
    check("locked_31", 32'(locked), 1);
    check("v_total_31", 32'(v_total), 31);
    frame(30, -1, 1'b1, 1'b0);
    frame(31, -1, 1'b0, 1'b1);
    check("unlocked_after_short_frame", 32'(locked), 0);
    frame(31, -1, 1'b0, 1'b0);
    frame(31, -1, 1'b0, 1'b0);

    // Locked frame with one 63-clock line.
    frame(31, 10, 1'b1, 1'b0);
    check("unlocked_after_short_line", 32'(locked), 0);
    check("h_total_after_short_line", 32'(h_total), LINE);
    frame(31, -1, 1'b0, 1'b0);
    frame(31, -1, 1'b0, 1'b0);
    frame(31, -1, 1'b1, 1'b0);
    check("relocked_after_line_err", 32'(locked), 1);

    // hsync stuck low: hpos reaches 1023 after 960 samples (last line ended at hpos 63).
    hold_low(1000, 1023 - LINE);
    check("locked_after_saturation", 32'(locked), 0);
    check("de_after_saturation", 32'(de), 0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b1, 1'b0);
    check("relocked_after_saturation", 32'(locked), 1);

    // Reset mid-frame at line 12.
    frame(12, -1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    q.delete();
    #1 outputs_zero("reset_mid");
    idle(3);
    check("sync_err_in_reset", 32'(sync_err), 0);
    reset = 1'b0;
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    frame(30, -1, 1'b0, 1'b0);
    check("unlocked_before_4th_edge", 32'(locked), 0);
    frame(30, -1, 1'b1, 1'b0);
    check("relocked_after_reset", 32'(locked), 1);
    check("h_total_after_reset", 32'(h_total), LINE);
    check("v_total_after_reset", 32'(v_total), 30);

    idle(4);
    check("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
